fifo_flex: RTL and testbench
============================

Name: fifo_flex

Overview:
- Parametrised successor to the fixed 30-entry sample FIFO used between the ultrasound front-end and the beamforming/logc stages.
- Data width and depth are independent parameters; any DEPTH >= 2 is supported, power-of-two or not, with explicit pointer wrap.
- Adds almost-full/almost-empty thresholds, a synchronous flush, sticky overflow/underflow error flags and a write-through-when-full rule.
- Read side is first-word-fall-through: data_out shows the head entry whenever out_valid=1.

Parameters:
DATA_WIDTH, 16, bits per entry
DEPTH, 30, number of entries (>= 2, any integer)
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  in  1  rising-edge clock, single clock domain
reset  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
data_in  in  DATA_WIDTH  write data
wr_en  in  1  write request
rd_en  in  1  read/pop request (head already visible on data_out)
flush  in  1  synchronous clear of contents, same priority class as reset but below it
err_clr  in  1  clears sticky overflow/underflow flags
data_out  out  DATA_WIDTH  head entry (FWFT); don't-care when out_valid=0
out_valid  out  1  FIFO non-empty
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
fifo_count  out  CW=$clog2(DEPTH+1)  entries held, 0..DEPTH
overflow  out  1  sticky: write attempted and rejected
underflow  out  1  sticky: read attempted and rejected

Behaviour:
- Storage: DEPTH x DATA_WIDTH array; wr_ptr, rd_ptr each $clog2(DEPTH) bits; count register CW bits. Full/empty derived from count, not pointer MSBs.
- Pointer advance: ptr == DEPTH-1 -> 0, else ptr+1. Pointers never reach DEPTH.
- Reset (reset=0 at clk edge): wr_ptr=rd_ptr=0, count=0, overflow=underflow=0. Therefore out_valid=0, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0) (effectively 0), fifo_count=0. Memory contents are not reset.
- Priority per edge: reset > flush > normal operation. Flush clears pointers and count; it leaves the error flags untouched. wr_en and rd_en in the flush cycle are ignored, with no error-flag effect.
- Write accept: wr_acc = wr_en & (!full | rd_acc). Data is written at wr_ptr and wr_ptr advances.
- Read accept: rd_acc = rd_en & out_valid. rd_ptr advances.
- Full and both enabled: both accepted; count unchanged; new word lands in the slot just vacated (wr_ptr == rd_ptr).
- Empty and both enabled: write accepted; read rejected (underflow set); next cycle count=1, out_valid=1.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Latency: a word written at edge N is on data_out, with out_valid=1, after edge N (one cycle) when the FIFO was empty. No combinational path from wr_en or data_in to outputs.
- Status outputs are combinational from count and rd_ptr only: out_valid=(count!=0), full=(count==DEPTH), plus the threshold compares.
- overflow: set on wr_en & !wr_acc (outside flush/reset). underflow: set on rd_en & !rd_acc (outside flush/reset).
- err_clr: clears both flags. A same-cycle new error wins: the flag stays 1.
- Reset mid-operation: all state returns to reset values at that edge; in-flight wr_en/rd_en are discarded.

Test Plan:
- Reset/idle: hold reset=0 for 2 cycles, then release -> fifo_count=0, out_valid=0, full=0, almost_empty=1, overflow=underflow=0.
- Fill/drain with non-power-of-two wrap (DEPTH=30):
  - Write 0x0001..0x001E -> full=1, count=30, almost_full from count 28.
  - A 31st write (0xBEEF) -> rejected, overflow=1, count stays 30.
  - Read 30 -> data_out sequence 0x0001..0x001E, then out_valid=0.
  - Repeat 3 times so both pointers wrap 29->0; order must be preserved.
- Simultaneous ops:
  - At full, wr_en=rd_en=1 with 0x1234 -> count stays 30, head advances; 0x1234 emerges as the 30th subsequent read.
  - At empty, both asserted -> count=1, underflow=1, data_out=written value next cycle.
- Flush/err_clr:
  - After 10 writes, flush=1 with wr_en=1 -> count=0, out_valid=0, overflow unchanged.
  - err_clr=1 alone clears both flags.
  - err_clr=1 with a rejected read -> underflow stays 1.
- Thresholds with DEPTH=5, AF_LEVEL=4, AE_LEVEL=1 -> almost_empty=1 at counts 0..1, almost_full=1 at counts 4..5; check each count step up and down.
- Reset mid-stream: with count=17, assert reset=0 together with wr_en=rd_en=1 -> next cycle count=0, flags 0; the first write after release reads back correctly.

Source files
------------

// File: rtl/fifo_flex_if.sv
// Handshake bundle for fifo_flex: producer/consumer controls on the master side,
// data and status returned from the FIFO on the slave side.
interface fifo_flex_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 30
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic                  flush;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  out_valid;
    logic                  full;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         fifo_count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output data_in, wr_en, rd_en, flush, err_clr,
        input  data_out, out_valid, full, almost_full, almost_empty,
               fifo_count, overflow, underflow
    );

    modport slave (
        input  data_in, wr_en, rd_en, flush, err_clr,
        output data_out, out_valid, full, almost_full, almost_empty,
               fifo_count, overflow, underflow
    );
endinterface

// File: rtl/fifo_flex.sv
// First-word-fall-through FIFO of any depth >= 2 with explicit pointer wrap,
// level thresholds, synchronous flush and sticky overflow/underflow flags.
module fifo_flex #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 30,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic        clk,
    input  logic        reset,
    fifo_flex_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic                  normal_s;
    logic                  valid_s;
    logic                  full_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic                  ovf_set_s;
    logic                  unf_set_s;
    logic [CW-1:0]         count_nxt_s;

    // Non-power-of-two depth: wrap on the last slot instead of on overflow.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PTR_LAST) begin
            n = {PW{1'b0}};
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    assign normal_s  = reset & ~bus.flush;
    assign valid_s   = (count_r != {CW{1'b0}});
    assign full_s    = (count_r == DEPTH_C);
    assign rd_acc_s  = normal_s & bus.rd_en & valid_s;
    assign wr_acc_s  = normal_s & bus.wr_en & (~full_s | rd_acc_s);
    assign ovf_set_s = normal_s & bus.wr_en & ~wr_acc_s;
    assign unf_set_s = normal_s & bus.rd_en & ~rd_acc_s;

    // Occupancy: simultaneous accept leaves count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array; contents deliberately survive reset and flush.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= bus.data_in;
        end
    end

    // Pointers, count and sticky error flags; flush keeps the flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r     <= count_nxt_s;
            overflow_r  <= ovf_set_s | (overflow_r & ~bus.err_clr);
            underflow_r <= unf_set_s | (underflow_r & ~bus.err_clr);
        end
    end

    assign bus.data_out     = mem_r[rd_ptr_r];
    assign bus.out_valid    = valid_s;
    assign bus.full         = full_s;
    assign bus.almost_full  = (count_r >= AF_C);
    assign bus.almost_empty = (count_r <= AE_C);
    assign bus.fifo_count   = count_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench: hand-written sequences on a 30-deep FIFO plus a vector table
// walking the thresholds of a 5-deep FIFO.
module tb_fifo_flex;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fifo_flex_if #(.DATA_WIDTH(16), .DEPTH(30)) bus_a ();
    fifo_flex_if #(.DATA_WIDTH(8),  .DEPTH(5))  bus_b ();

    fifo_flex #(.DATA_WIDTH(16), .DEPTH(30)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    fifo_flex #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic       ec;
        logic [7:0] din;
        logic [2:0] cnt;
        logic       ae;
        logic       af;
        logic       full;
        logic       vld;
        logic       ovf;
        logic       unf;
        logic       chkd;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step_a(input logic wr, input logic rd, input logic fl,
                          input logic ec, input logic [15:0] d);
        bus_a.wr_en = wr; bus_a.rd_en = rd; bus_a.flush = fl;
        bus_a.err_clr = ec; bus_a.data_in = d;
        @(posedge clk);
        #1;
        bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0; bus_a.flush = 1'b0; bus_a.err_clr = 1'b0;
    endtask

    task automatic step_b(input logic wr, input logic rd, input logic ec, input logic [7:0] d);
        bus_b.wr_en = wr; bus_b.rd_en = rd; bus_b.flush = 1'b0;
        bus_b.err_clr = ec; bus_b.data_in = d;
        @(posedge clk);
        #1;
        bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0; bus_b.err_clr = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0; bus_a.flush = 1'b0;
        bus_a.err_clr = 1'b0; bus_a.data_in = 16'h0000;
        bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0; bus_b.flush = 1'b0;
        bus_b.err_clr = 1'b0; bus_b.data_in = 8'h00;

        //             wr    rd    ec    din    cnt   ae    af    full  vld   ovf   unf   chkd  dout
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h11, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h22, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h33, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h44, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h55, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h99, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h66, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h66};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        // Reset and idle state
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_count", bus_a.fifo_count, 0);
        chk("rst_valid", bus_a.out_valid, 0);
        chk("rst_full", bus_a.full, 0);
        chk("rst_ae", bus_a.almost_empty, 1);
        chk("rst_af", bus_a.almost_full, 0);
        chk("rst_ovf", bus_a.overflow, 0);
        chk("rst_unf", bus_a.underflow, 0);

        // One-cycle fall-through latency; also offsets pointers so rounds wrap mid-way
        step_a(1'b1, 1'b0, 1'b0, 1'b0, 16'h00AA);
        chk("lat_valid", bus_a.out_valid, 1);
        chk("lat_data", bus_a.data_out, 16'h00AA);
        chk("lat_count", bus_a.fifo_count, 1);
        step_a(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("lat_drain", bus_a.fifo_count, 0);

        // Fill, overflow, drain: three rounds crossing the 29 -> 0 wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 30; i++) begin
                step_a(1'b1, 1'b0, 1'b0, 1'b0, 16'((r << 8) | (i + 1)));
                chk("fill_count", bus_a.fifo_count, i + 1);
                chk("fill_af", bus_a.almost_full, ((i + 1) >= 28) ? 1 : 0);
                chk("fill_ae", bus_a.almost_empty, ((i + 1) <= 2) ? 1 : 0);
                chk("fill_full", bus_a.full, ((i + 1) == 30) ? 1 : 0);
            end
            step_a(1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF);
            chk("ovf_flag", bus_a.overflow, 1);
            chk("ovf_count", bus_a.fifo_count, 30);
            for (int i = 0; i < 30; i++) begin
                chk("drain_valid", bus_a.out_valid, 1);
                chk("drain_data", bus_a.data_out, (r << 8) | (i + 1));
                step_a(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
                chk("drain_count", bus_a.fifo_count, 29 - i);
            end
            chk("drain_empty", bus_a.out_valid, 0);
        end

        // Simultaneous read/write while full
        for (int i = 0; i < 30; i++) begin
            step_a(1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h0100 + i));
        end
        step_a(1'b1, 1'b1, 1'b0, 1'b0, 16'h1234);
        chk("fullrw_count", bus_a.fifo_count, 30);
        chk("fullrw_full", bus_a.full, 1);
        for (int i = 0; i < 30; i++) begin
            chk("fullrw_data", bus_a.data_out, (i < 29) ? (16'h0101 + i) : 16'h1234);
            step_a(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        end
        chk("fullrw_empty", bus_a.out_valid, 0);

        // Simultaneous read/write while empty
        step_a(1'b1, 1'b1, 1'b0, 1'b0, 16'h5A5A);
        chk("emptyrw_count", bus_a.fifo_count, 1);
        chk("emptyrw_unf", bus_a.underflow, 1);
        chk("emptyrw_valid", bus_a.out_valid, 1);
        chk("emptyrw_data", bus_a.data_out, 16'h5A5A);
        step_a(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

        // err_clr alone clears both sticky flags
        step_a(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        chk("clr_ovf", bus_a.overflow, 0);
        chk("clr_unf", bus_a.underflow, 0);

        // Flush discards contents and same-cycle requests, keeps flags
        step_a(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("pre_flush_unf", bus_a.underflow, 1);
        for (int i = 0; i < 10; i++) begin
            step_a(1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h0300 + i));
        end
        chk("pre_flush_count", bus_a.fifo_count, 10);
        step_a(1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFF);
        chk("flush_count", bus_a.fifo_count, 0);
        chk("flush_valid", bus_a.out_valid, 0);
        chk("flush_unf", bus_a.underflow, 1);
        chk("flush_ovf", bus_a.overflow, 0);

        // New error beats err_clr in the same cycle
        step_a(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
        chk("clr_race_unf", bus_a.underflow, 1);
        step_a(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        chk("clr_after_unf", bus_a.underflow, 0);

        // Reset mid-stream with requests in flight
        step_a(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 17; i++) begin
            step_a(1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h0200 + i));
        end
        chk("mid_count", bus_a.fifo_count, 17);
        reset = 1'b0;
        step_a(1'b1, 1'b1, 1'b0, 1'b0, 16'hDEAD);
        reset = 1'b1;
        chk("mid_rst_count", bus_a.fifo_count, 0);
        chk("mid_rst_valid", bus_a.out_valid, 0);
        chk("mid_rst_unf", bus_a.underflow, 0);
        chk("mid_rst_ovf", bus_a.overflow, 0);
        step_a(1'b1, 1'b0, 1'b0, 1'b0, 16'h7777);
        chk("post_rst_data", bus_a.data_out, 16'h7777);
        chk("post_rst_count", bus_a.fifo_count, 1);

        // Threshold table on the 5-deep instance (reset above also cleared it)
        chk("b_init_ae", bus_b.almost_empty, 1);
        chk("b_init_af", bus_b.almost_full, 0);
        for (int k = 0; k < 14; k++) begin
            step_b(tbl[k].wr, tbl[k].rd, tbl[k].ec, tbl[k].din);
            chk($sformatf("b%0d_count", k), bus_b.fifo_count, tbl[k].cnt);
            chk($sformatf("b%0d_ae", k), bus_b.almost_empty, tbl[k].ae);
            chk($sformatf("b%0d_af", k), bus_b.almost_full, tbl[k].af);
            chk($sformatf("b%0d_full", k), bus_b.full, tbl[k].full);
            chk($sformatf("b%0d_valid", k), bus_b.out_valid, tbl[k].vld);
            chk($sformatf("b%0d_ovf", k), bus_b.overflow, tbl[k].ovf);
            chk($sformatf("b%0d_unf", k), bus_b.underflow, tbl[k].unf);
            if (tbl[k].chkd) begin
                chk($sformatf("b%0d_data", k), bus_b.data_out, tbl[k].dout);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
